// File: rtl/data_sampling_mv_pkg.sv
// data_sampling_pkg: shared types and constants for the data_sampling_mv oversampler.
//   state_t           - voter FSM encoding (IDLE, COLLECT, VOTE)
//   DEF_PRESCALE_W    - default prescale / edge_cnt width
//   DEF_NUM_SAMPLES   - default samples per bit (odd, 1..7)
//   MIN_PRESCALE_FACTOR - prescale must be at least this times NUM_SAMPLES
//   calc_window()     - sampling window bounds centred on prescale/2
package data_sampling_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, VOTE} state_t;

   localparam int DEF_PRESCALE_W      = 6;
   localparam int DEF_NUM_SAMPLES     = 3;
   localparam int MIN_PRESCALE_FACTOR = 2;

   // Wide enough for any practical prescale; callers truncate to PRESCALE_W+1.
   localparam int WIN_MAX_W = 17;

   typedef struct packed {
      logic [WIN_MAX_W-1:0] lo;
      logic [WIN_MAX_W-1:0] hi;
   } win_t;

   // Window = mid-HALF .. mid+HALF. Underflow cannot reach the FSM because
   // prescale < 2*num_samples is flagged as a configuration error and blocked.
   function automatic win_t calc_window(input logic [WIN_MAX_W-1:0] prescale,
                                        input int num_samples);
      win_t                 w;
      logic [WIN_MAX_W-1:0] mid;
      logic [WIN_MAX_W-1:0] half;
      mid  = prescale >> 1;
      half = WIN_MAX_W'((num_samples - 1) / 2);
      w.lo = mid - half;
      w.hi = mid + half;
      return w;
   endfunction

endpackage

// File: rtl/data_sampling_mv_if.sv
// data_sampling_mv_if: bus between the UART_RX control side and the oversampler.
//   master: drives prescale, RX_IN, dat_samp_en, edge_cnt; reads the vote results.
//   slave : the oversampler; drives sampled_bit, sample_valid, sample_noisy, cfg_err.
interface data_sampling_mv_if
   import data_sampling_pkg::*;
#(
   parameter int PRESCALE_W = DEF_PRESCALE_W
);
   logic [PRESCALE_W-1:0] prescale;
   logic                  RX_IN;
   logic                  dat_samp_en;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic                  sampled_bit;
   logic                  sample_valid;
   logic                  sample_noisy;
   logic                  cfg_err;

   modport master (
      output prescale, RX_IN, dat_samp_en, edge_cnt,
      input  sampled_bit, sample_valid, sample_noisy, cfg_err
   );

   modport slave (
      input  prescale, RX_IN, dat_samp_en, edge_cnt,
      output sampled_bit, sample_valid, sample_noisy, cfg_err
   );
endinterface

// File: rtl/data_sampling_mv_rx_sync_2ff.sv
// rx_sync_2ff: two-flop synchroniser for an asynchronous serial input.
//   CLK  - destination clock
//   RST  - asynchronous active-low reset; both flops load RST_VAL
//   d    - asynchronous input
//   q    - synchronised output, two CLK behind d
module rx_sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);
   logic [1:0] ff;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) ff <= {2{RST_VAL}};
      else      ff <= {ff[0], d};
   end

   assign q = ff[1];
endmodule

// File: rtl/data_sampling_mv.sv
// data_sampling_mv: majority-vote oversampler for the UART_RX path.
// Takes NUM_SAMPLES consecutive RX_IN samples in a window centred on
// prescale/2 of each bit and reports the voted bit two CLK after the last
// sample, with a one-cycle valid strobe and a noise flag.
//   CLK, RST - clock, asynchronous active-low reset
//   bus      - data_sampling_mv_if.slave (prescale, RX_IN, dat_samp_en,
//              edge_cnt in; sampled_bit, sample_valid, sample_noisy, cfg_err out)
// Build option DATA_SAMPLING_SYNC_EN: RX_IN goes through a 2-flop
// synchroniser (idle-high reset) before sampling; otherwise RX_IN is taken
// as already synchronous to CLK.
module data_sampling_mv
   import data_sampling_pkg::*;
#(
   parameter int PRESCALE_W  = DEF_PRESCALE_W,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
   input  logic              CLK,
   input  logic              RST,
   data_sampling_mv_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
   localparam int HALF  = (NUM_SAMPLES - 1) / 2;
   localparam int WW    = PRESCALE_W + 1;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n, ones_q, ones_n;
   logic [CNT_W-1:0] cnt_inc, ones_add;
   logic             bit_q, valid_q, noisy_q, cfg_err_q;
   logic             rx_s, cfg_bad, blk, take, do_vote;
   win_t             win;
   logic [WW-1:0]    w_lo, exp_edge, edge_x;

`ifdef DATA_SAMPLING_SYNC_EN
   rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (bus.RX_IN),
      .q   (rx_s)
   );
`else
   assign rx_s = bus.RX_IN;
`endif

   assign win  = calc_window(WIN_MAX_W'(bus.prescale), NUM_SAMPLES);
   assign w_lo = win.lo[WW-1:0];

   assign cfg_bad = 32'(bus.prescale) < 32'(MIN_PRESCALE_FACTOR * NUM_SAMPLES);
   // Block on both the live and the registered flag so no sample slips in
   // during the cycle in which prescale becomes illegal.
   assign blk = cfg_bad | cfg_err_q;

   // Samples must land on consecutive edges starting at W_LO; any other
   // edge (skip, counter reset, leaving the window) aborts the bit. The last
   // expected edge is W_LO+NUM_SAMPLES-1 = W_HI.
   assign edge_x   = {1'b0, bus.edge_cnt};
   assign exp_edge = w_lo + WW'(cnt_q);
   assign take     = bus.dat_samp_en & ~blk & (edge_x == exp_edge);
   assign cnt_inc  = cnt_q + 1'b1;
   assign ones_add = ones_q + CNT_W'(rx_s);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ones_q    <= '0;
         bit_q     <= 1'b0;
         valid_q   <= 1'b0;
         noisy_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         ones_q    <= ones_n;
         cfg_err_q <= cfg_bad;
         valid_q   <= do_vote;
         if (do_vote) begin
            bit_q   <= ones_q > CNT_W'(HALF);
            noisy_q <= (ones_q != '0) && (ones_q != CNT_W'(NUM_SAMPLES));
         end
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = '0;
      ones_n  = '0;
      do_vote = 1'b0;
      case (state_q)
         // IDLE has cnt_q==0, so exp_edge==W_LO and the same rule starts a bit.
         IDLE, COLLECT: begin
            if (take) begin
               cnt_n   = cnt_inc;
               ones_n  = ones_add;
               state_n = (cnt_inc == CNT_W'(NUM_SAMPLES)) ? VOTE : COLLECT;
            end else begin
               state_n = IDLE;
            end
         end
         VOTE: begin
            do_vote = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.sampled_bit  = bit_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_noisy = noisy_q;
   assign bus.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// tb_data_sampling_mv: directed bench for data_sampling_mv.
// Two instances share one stimulus stream: u3 (NUM_SAMPLES=3) and
// u5 (NUM_SAMPLES=5), both PRESCALE_W=6.
module tb_data_sampling_mv;
   localparam int PW = 6;
`ifdef DATA_SAMPLING_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          CLK = 1'b0;
   logic          RST;
   logic [PW-1:0] prescale;
   logic [PW-1:0] edge_cnt;
   logic          rx, en;
   int            checks = 0, failures = 0;
   int            n3 = 0, n5 = 0, b3, b5;

   always #5 CLK = ~CLK;

   data_sampling_mv_if #(.PRESCALE_W(PW)) if3 ();
   data_sampling_mv_if #(.PRESCALE_W(PW)) if5 ();

   assign if3.prescale    = prescale;
   assign if3.edge_cnt    = edge_cnt;
   assign if3.RX_IN       = rx;
   assign if3.dat_samp_en = en;
   assign if5.prescale    = prescale;
   assign if5.edge_cnt    = edge_cnt;
   assign if5.RX_IN       = rx;
   assign if5.dat_samp_en = en;

   data_sampling_mv #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) u3 (.CLK(CLK), .RST(RST), .bus(if3));
   data_sampling_mv #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) u5 (.CLK(CLK), .RST(RST), .bus(if5));

   // Valid pulses are counted once per cycle, half a period after the edge.
   always @(negedge CLK) begin
      if (if3.sample_valid) n3++;
      if (if5.sample_valid) n5++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int e, input logic r, input logic en_i);
      @(negedge CLK);
      #1;
      edge_cnt = PW'(e);
      rx       = r;
      en       = en_i;
   endtask

   // One bit period: rxv[e] is the line value wanted at the sampler on edge
   // e, env[e] the enable, skipv[e] drops edge e from the sequence.
   task automatic run_bit(input logic [31:0] rxv, input logic [31:0] env,
                          input logic [31:0] skipv);
      for (int e = 0; e < int'(prescale); e++) begin
         if (!skipv[e]) step(e, rxv[e+LAT], env[e]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] rxv;
      RST = 1'b0; prescale = 6'd8; edge_cnt = '0; rx = 1'b1; en = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_bit", if3.sampled_bit, 0);
      chk("rst_valid", if3.sample_valid, 0);
      chk("rst_noisy", if3.sample_noisy, 0);
      chk("rst_cfg3", if3.cfg_err, 0);
      chk("rst_cfg5", if5.cfg_err, 0);
      RST = 1'b1;

      // 1,0,1 on edges 3,4,5 of an 8-edge bit: vote 1, noisy, pulse at W_HI+2.
      b3 = n3; b5 = n5;
      rxv = ~32'h10;
      for (int e = 0; e < 8; e++) begin
         step(e, rxv[e+LAT], 1'b1);
         if (e == 6) chk("t1_valid_early", if3.sample_valid, 0);
         if (e == 7) begin
            chk("t1_valid", if3.sample_valid, 1);
            chk("t1_bit", if3.sampled_bit, 1);
            chk("t1_noisy", if3.sample_noisy, 1);
         end
      end
      step(7, 1'b1, 1'b1);
      chk("t1_valid_1cyc", if3.sample_valid, 0);
      chk("t1_pulses3", n3 - b3, 1);
      chk("t1_cfg5", if5.cfg_err, 1);
      chk("t1_pulses5", n5 - b5, 0);

      // prescale=16, all zeros, 10 bits: one pulse per bit on both voters.
      prescale = 6'd16; b3 = n3; b5 = n5;
      repeat (10) run_bit(32'h0, '1, 32'h0);
      chk("t2_pulses3", n3 - b3, 10);
      chk("t2_pulses5", n5 - b5, 10);
      chk("t2_bit3", if3.sampled_bit, 0);
      chk("t2_bit5", if5.sampled_bit, 0);
      chk("t2_noisy5", if5.sample_noisy, 0);
      chk("t2_cfg5", if5.cfg_err, 0);

      // Enable dropped at edge 4, skipped edge, late enable: all abort.
      prescale = 6'd8; b3 = n3;
      run_bit('1, 32'h0F, 32'h0);
      chk("t3_drop_pulses", n3 - b3, 0);
      chk("t3_drop_bit", if3.sampled_bit, 0);
      run_bit('1, '1, 32'h0);
      chk("t3_next_pulses", n3 - b3, 1);
      chk("t3_next_bit", if3.sampled_bit, 1);
      chk("t3_next_noisy", if3.sample_noisy, 0);
      run_bit(32'h0, '1, 32'h10);
      chk("t3_skip_pulses", n3 - b3, 1);
      chk("t3_skip_bit", if3.sampled_bit, 1);
      run_bit(32'h0, 32'hF0, 32'h0);
      chk("t3_late_pulses", n3 - b3, 1);
      run_bit(32'h0, '1, 32'h0);
      chk("t3_after_bit", if3.sampled_bit, 0);

      // prescale=4 is below 2*3: flag set, nothing sampled.
      prescale = 6'd4;
      step(3, 1'b0, 1'b1);
      chk("t4_cfg_set", if3.cfg_err, 1);
      b3 = n3;
      repeat (3) run_bit(32'h0, '1, 32'h0);
      step(3, 1'b0, 1'b1);
      prescale = 6'd8;
      chk("t4_cfg_held", if3.cfg_err, 1);
      step(7, 1'b0, 1'b1);
      chk("t4_cfg_clr", if3.cfg_err, 0);
      chk("t4_blocked_pulses", n3 - b3, 0);
      run_bit('1, '1, 32'h0);
      chk("t4_resume_pulses", n3 - b3, 1);
      chk("t4_resume_bit", if3.sampled_bit, 1);

      // Reset at edge 4 mid-window: outputs drop without a clock edge.
      b3 = n3;
      for (int e = 0; e <= 4; e++) step(e, 1'b1, 1'b1);
      #1 RST = 1'b0;
      #1;
      chk("t5_bit", if3.sampled_bit, 0);
      chk("t5_valid", if3.sample_valid, 0);
      chk("t5_cfg5", if5.cfg_err, 0);
      @(negedge CLK);
      #1 RST = 1'b1;
      for (int e = 5; e < 8; e++) step(e, 1'b1, 1'b1);
      chk("t5_no_pulse", n3 - b3, 0);
      run_bit('1, '1, 32'h0);
      chk("t5_full_pulses", n3 - b3, 1);
      chk("t5_full_bit", if3.sampled_bit, 1);

`ifdef DATA_SAMPLING_SYNC_EN
      // Raw line steps 0->1 at edge 2; synchronised samples at 3,4,5 read 0,1,1.
      b3 = n3;
      for (int e = 0; e < 8; e++) step(e, (e >= 2), 1'b1);
      chk("t6_pulses", n3 - b3, 1);
      chk("t6_bit", if3.sampled_bit, 1);
      chk("t6_noisy", if3.sample_noisy, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
